// File: rtl/reg_file_2r1w.sv
// rtl/reg_file_2r1w.sv - DEPTH x DATA_WIDTH register bank, one write port, two registered read ports, sweep clear
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   we, waddr, wdata      synchronous write port (ignored while busy or waddr >= DEPTH)
//   re_a, raddr_a, rdata_a  registered read port A (1-cycle latency, holds when re_a=0)
//   re_b, raddr_b, rdata_b  registered read port B
//   clr_req               single-cycle request to zero every entry, one entry per cycle
//   busy                  high while the clear sweep runs (exactly DEPTH cycles)
//   parity_err_a/_b       stored-parity mismatch flags, only with RF_PARITY_EN
//
// Optional feature macro: RF_PARITY_EN (adds an even-parity bit per entry and the
// parity_err_a/parity_err_b outputs). Undefined by default.

module reg_file_2r1w #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re_a,
  input  logic [ADDR_WIDTH-1:0] raddr_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  input  logic                  re_b,
  input  logic [ADDR_WIDTH-1:0] raddr_b,
  output logic [DATA_WIDTH-1:0] rdata_b,
  input  logic                  clr_req,
  output logic                  busy
`ifdef RF_PARITY_EN
  ,
  output logic                  parity_err_a,
  output logic                  parity_err_b
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_X  = (ADDR_WIDTH + 1)'(DEPTH);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  wr_acc;
  logic                  byp_a;
  logic                  byp_b;
  logic [DATA_WIDTH-1:0] rd_a;
  logic [DATA_WIDTH-1:0] rd_b;

  // busy is the registered state itself, so it rises the cycle after clr_req is sampled.
  assign busy   = (state_q == SWEEP);
  assign wr_acc = we && (state_q == IDLE) && ({1'b0, waddr} < DEPTH_X);
  assign byp_a  = wr_acc && re_a && (raddr_a == waddr);
  assign byp_b  = wr_acc && re_b && (raddr_b == waddr);

  // Clear sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clr_req) begin
            state_q <= SWEEP;
            cnt_q   <= '0;
          end
        end
        SWEEP: begin
          if (cnt_q == LAST_IDX) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Storage. Writes and sweep clears are mutually exclusive because writes are
  // only accepted in IDLE; address matching by loop avoids indexing past DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((state_q == SWEEP) && (cnt_q == ADDR_WIDTH'(i))) begin
          mem_q[i] <= '0;
        end else if (wr_acc && (waddr == ADDR_WIDTH'(i))) begin
          mem_q[i] <= wdata;
        end
      end
    end
  end

  // Read muxes; an address with no matching entry falls through to 0.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr_a == ADDR_WIDTH'(i)) rd_a = mem_q[i];
      if (raddr_b == ADDR_WIDTH'(i)) rd_b = mem_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      if (re_a) rdata_a <= byp_a ? wdata : rd_a;
      if (re_b) rdata_b <= byp_b ? wdata : rd_b;
    end
  end

`ifdef RF_PARITY_EN
  logic par_q [DEPTH];
  logic rp_a;
  logic rp_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        par_q[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((state_q == SWEEP) && (cnt_q == ADDR_WIDTH'(i))) begin
          par_q[i] <= 1'b0;
        end else if (wr_acc && (waddr == ADDR_WIDTH'(i))) begin
          par_q[i] <= ^wdata;
        end
      end
    end
  end

  always_comb begin
    rp_a = 1'b0;
    rp_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr_a == ADDR_WIDTH'(i)) rp_a = par_q[i];
      if (raddr_b == ADDR_WIDTH'(i)) rp_b = par_q[i];
    end
  end

  // Out-of-range reads see data 0 / parity 0 and therefore report no error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err_a <= 1'b0;
      parity_err_b <= 1'b0;
    end else begin
      if (re_a) parity_err_a <= byp_a ? 1'b0 : ((^rd_a) != rp_a);
      if (re_b) parity_err_b <= byp_b ? 1'b0 : ((^rd_b) != rp_b);
    end
  end
`endif

endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb/tb_reg_file_2r1w.sv - scoreboard bench for reg_file_2r1w (DEPTH=8 main instance, DEPTH=6 range instance)

module tb_reg_file_2r1w;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       we = 1'b0;
  logic [2:0] waddr = '0;
  logic [7:0] wdata = '0;
  logic       re_a = 1'b0;
  logic [2:0] raddr_a = '0;
  logic       re_b = 1'b0;
  logic [2:0] raddr_b = '0;
  logic       clr_req = 1'b0;
  logic [7:0] rdata_a, rdata_b, rdata_a6, rdata_b6;
  logic       busy, busy6;
`ifdef RF_PARITY_EN
  logic       perr_a, perr_b, perr_a6, perr_b6;
`endif

  always #5 clk = ~clk;

  reg_file_2r1w #(.DATA_WIDTH(8), .DEPTH(8), .ADDR_WIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b),
    .clr_req(clr_req), .busy(busy)
`ifdef RF_PARITY_EN
    , .parity_err_a(perr_a), .parity_err_b(perr_b)
`endif
  );

  reg_file_2r1w #(.DATA_WIDTH(8), .DEPTH(6), .ADDR_WIDTH(3)) dut6 (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a6),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b6),
    .clr_req(clr_req), .busy(busy6)
`ifdef RF_PARITY_EN
    , .parity_err_a(perr_a6), .parity_err_b(perr_b6)
`endif
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
  } exp_t;

  exp_t       sb_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  // Reference model of the DEPTH=8 instance
  logic [7:0] mdl [8];
  logic [7:0] m_a, m_b;
  logic       m_busy;
  int         m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
    m_a    = 8'h00;
    m_b    = 8'h00;
    m_busy = 1'b0;
    m_cnt  = 0;
  endtask

  // Advance the model by one clock edge using the currently driven inputs
  task automatic model_edge();
    logic acc;
    exp_t e;
    acc = we && !m_busy;
    if (re_a) m_a = (acc && raddr_a == waddr) ? wdata : mdl[raddr_a];
    if (re_b) m_b = (acc && raddr_b == waddr) ? wdata : mdl[raddr_b];
    if (acc) mdl[waddr] = wdata;
    if (m_busy) begin
      mdl[m_cnt] = 8'h00;
      if (m_cnt == 7) m_busy = 1'b0;
      m_cnt++;
    end else if (clr_req) begin
      m_busy = 1'b1;
      m_cnt  = 0;
    end
    e.a    = m_a;
    e.b    = m_b;
    e.busy = m_busy;
    sb_q.push_back(e);
  endtask

  task automatic step(input logic w, input logic [2:0] wa, input logic [7:0] wd,
                      input logic ea, input logic [2:0] ra,
                      input logic eb, input logic [2:0] rb,
                      input logic clr, input string tag);
    exp_t e;
    @(negedge clk);
    we = w; waddr = wa; wdata = wd;
    re_a = ea; raddr_a = ra; re_b = eb; raddr_b = rb;
    clr_req = clr;
    model_edge();
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_eq({tag, "_rdata_a"}, rdata_a, e.a);
    check_eq({tag, "_rdata_b"}, rdata_b, e.b);
    check_eq({tag, "_busy"}, busy, e.busy);
  endtask

  task automatic idle(input string tag);
    step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, tag);
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq({tag, "_rst_rdata_a"}, rdata_a, 32'h0);
    check_eq({tag, "_rst_rdata_b"}, rdata_b, 32'h0);
    check_eq({tag, "_rst_busy"}, busy, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int busy_cnt;
  logic [7:0] mid_sweep_rd;

  initial begin
    model_reset();
    #1;
    check_eq("init_rdata_a", rdata_a, 32'h0);
    check_eq("init_rdata_b", rdata_b, 32'h0);
    check_eq("init_busy", busy, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset contents
    for (int i = 0; i < 8; i += 2) begin
      step(1'b0, 3'd0, 8'h00, 1'b1, 3'(i), 1'b1, 3'(i + 1), 1'b0, "rst_contents");
      check_eq("rst_contents_a_zero", rdata_a, 32'h0);
    end

    // Basic write then read
    step(1'b1, 3'd3, 8'hA5, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, "wr3");
    step(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 1'b1, 3'd0, 1'b0, "rd3");
    check_eq("basic_a", rdata_a, 32'hA5);
    check_eq("basic_b", rdata_b, 32'h00);
    idle("hold");
    check_eq("hold_a", rdata_a, 32'hA5);

    // Dual bypass
    step(1'b1, 3'd5, 8'h3C, 1'b1, 3'd5, 1'b1, 3'd5, 1'b0, "bypass");
    check_eq("bypass_a", rdata_a, 32'h3C);
    check_eq("bypass_b", rdata_b, 32'h3C);

    // Fill and sweep
    for (int i = 0; i < 8; i++)
      step(1'b1, 3'(i), 8'((i + 1) * 8'h11), 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, "fill");
    step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, "clr");
    busy_cnt = busy ? 1 : 0;
    mid_sweep_rd = 8'h00;
    for (int k = 0; k < 10; k++) begin
      if (k == 1)
        step(1'b1, 3'd7, 8'hFF, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, "wr_busy");
      else if (k == 3) begin
        step(1'b0, 3'd0, 8'h00, 1'b1, 3'd7, 1'b0, 3'd0, 1'b0, "rd_sweep");
        mid_sweep_rd = rdata_a;
      end else
        idle("sweep");
      if (busy) busy_cnt++;
    end
    check_eq("busy_cycles", busy_cnt, 32'd8);
    check_eq("mid_sweep_rd7", mid_sweep_rd, 32'h88);
    for (int i = 0; i < 8; i += 2) begin
      step(1'b0, 3'd0, 8'h00, 1'b1, 3'(i), 1'b1, 3'(i + 1), 1'b0, "post_clr");
      check_eq("post_clr_a", rdata_a, 32'h0);
      check_eq("post_clr_b", rdata_b, 32'h0);
    end

    // Clear together with a write: the write lands, the sweep then clears it
    step(1'b1, 3'd6, 8'h66, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, "wr_clr");
    step(1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 1'b0, 3'd0, 1'b0, "wr_clr_rd");
    check_eq("wr_clr_landed", rdata_a, 32'h66);
    repeat (8) idle("wr_clr_sweep");
    step(1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 1'b0, 3'd0, 1'b0, "wr_clr_after");
    check_eq("wr_clr_cleared", rdata_a, 32'h0);

    // Out-of-range on the DEPTH=6 instance
    step(1'b1, 3'd7, 8'h5A, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, "oor_wr7");
    step(1'b1, 3'd5, 8'h77, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, "oor_wr5");
    step(1'b0, 3'd0, 8'h00, 1'b1, 3'd7, 1'b1, 3'd5, 1'b0, "oor_rd");
    check_eq("d8_rd7", rdata_a, 32'h5A);
    check_eq("d6_rd7", rdata_a6, 32'h0);
    check_eq("d6_rd5", rdata_b6, 32'h77);
    step(1'b1, 3'd6, 8'h99, 1'b1, 3'd6, 1'b0, 3'd0, 1'b0, "oor_byp6");
    check_eq("d6_no_bypass_oor", rdata_a6, 32'h0);

    // Reset mid-sweep
    step(1'b1, 3'd4, 8'h44, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, "pre_abort");
    idle("abort_sweep");
    async_reset("mid_sweep");
    for (int i = 0; i < 8; i += 2) begin
      step(1'b0, 3'd0, 8'h00, 1'b1, 3'(i), 1'b1, 3'(i + 1), 1'b0, "after_abort");
      check_eq("after_abort_busy6", busy6, 32'h0);
    end
    step(1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 1'b1, 3'd7, 1'b0, "after_abort_rd");
    check_eq("after_abort_4", rdata_a, 32'h0);
    check_eq("after_abort_7", rdata_b, 32'h0);

`ifdef RF_PARITY_EN
    step(1'b1, 3'd1, 8'h07, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, "par_wr");
    step(1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 1'b1, 3'd0, 1'b0, "par_clean");
    check_eq("par_clean_a", perr_a, 32'h0);
    @(negedge clk);
    dut.par_q[1] = ~dut.par_q[1];
    step(1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 1'b1, 3'd0, 1'b0, "par_inj");
    check_eq("par_inj_data", rdata_a, 32'h07);
    check_eq("par_inj_err_a", perr_a, 32'h1);
    check_eq("par_inj_err_b", perr_b, 32'h0);
    step(1'b1, 3'd2, 8'h01, 1'b1, 3'd2, 1'b0, 3'd0, 1'b0, "par_byp");
    check_eq("par_byp_err", perr_a, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
